// File: rtl/mult_pkg.sv
// mult_pkg: shared widths, state encoding and iteration bound for the shift-add multiplier
package mult_pkg;
    localparam int MULT_W = 16;
    localparam int CNT_W = 5;
    localparam int LAST_ITER = 15;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/brent_kung_16.sv
// brent_kung_16: 16-bit Brent-Kung prefix adder with carry-in and carry-out
module brent_kung_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [15:0] p, gg, pp;
    always_comb begin
        p = a ^ b;
        gg = a & b;
        pp = p;
        gg[0] = gg[0] | (p[0] & cin);
        for (int l = 0; l < 4; l++)
            for (int i = (2 << l) - 1; i < 16; i += 2 << l) begin
                gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                pp[i] = pp[i] & pp[i - (1 << l)];
            end
        // down-sweep fills in the prefixes the up-sweep tree skipped
        for (int l = 2; l >= 0; l--)
            for (int i = (3 << l) - 1; i < 16; i += 2 << l) begin
                gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                pp[i] = pp[i] & pp[i - (1 << l)];
            end
        sum = p ^ {gg[14:0], cin};
        cout = gg[15];
    end
endmodule

// File: rtl/seq_shift_add_mult16.sv
// seq_shift_add_mult16: iterative radix-2 shift-add 16x16 unsigned multiplier with valid/ready handshakes
// SEQ_MULT_EARLY_TERM_EN: finish early once the remaining multiplier bits are all zero
module seq_shift_add_mult16 import mult_pkg::*; #(
    parameter int WIDTH = MULT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);
    state_t state, next;
    logic [WIDTH-1:0] mcand, acc_hi, q, s;
    logic [CNT_W-1:0] count;
    logic [2*WIDTH-1:0] step;
    logic c, skip;
    brent_kung_16 u_add (
        .a(acc_hi),
        .b(q[0] ? mcand : '0),
        .cin(1'b0),
        .sum(s),
        .cout(c)
    );
`ifdef SEQ_MULT_EARLY_TERM_EN
    assign skip = (q << count) == '0;
    assign step = skip ? {acc_hi, q} >> (WIDTH - int'(count)) : {c, s, q[WIDTH-1:1]};
`else
    assign skip = 1'b0;
    assign step = {c, s, q[WIDTH-1:1]};
`endif
    assign in_ready = (state == IDLE) && !rst;
    assign out_valid = state == DONE;
    assign product = out_valid ? {acc_hi, q} : '0;
    always_comb begin
        next = state;
        next = state == IDLE ? (in_valid ? BUSY : IDLE)
             : state == BUSY ? ((skip || count == CNT_W'(LAST_ITER)) ? DONE : BUSY)
             : (out_ready ? IDLE : DONE);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mcand <= '0;
            acc_hi <= '0;
            q <= '0;
            count <= '0;
        end else begin
            state <= next;
            if (state == IDLE && in_valid) begin
                mcand <= a;
                q <= b;
                acc_hi <= '0;
                count <= '0;
            end else if (state == BUSY) begin
                {acc_hi, q} <= step;
                count <= count + CNT_W'(1);
            end
        end
    end
endmodule

// File: doc/seq_shift_add_mult16.md
# seq_shift_add_mult16

Iterative 16x16 unsigned radix-2 shift-add multiplier producing a 32-bit product. It is the stage directly upstream of the team's `brent_kung_16` adder: each cycle it drives one partial-product addition into that adder and consumes the sum and carry-out. Valid/ready handshakes on input and output let it drop into the multiplier test harnesses alongside the combinational trees.

## Interface
- `WIDTH`, 16: operand width. 16 is the only supported value because it is tied to the adder width.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operands `a`/`b` are valid.
- `in_ready` output 1: block accepts operands. Equals (state==IDLE) && !rst.
- `a` input 16: multiplicand, unsigned.
- `b` input 16: multiplier, unsigned.
- `out_valid` output 1: `product` is valid.
- `out_ready` input 1: consumer takes the product.
- `product` output 32: a*b.

## Operation
- Registers:
  - `mcand[15:0]`
  - `acc_hi[15:0]`
  - `q[15:0]`: holds the multiplier bits, shifting product bits in from the top.
  - `count[4:0]`
  - `state`
- States and transitions:
  - IDLE: on in_valid && in_ready, load mcand=a, q=b, acc_hi=0, count=0, then go to BUSY.
  - BUSY, one iteration per cycle:
    - Adder inputs are in1=acc_hi and in2 = q[0] ? mcand : 0, with cin=0, giving {c,s}.
    - Update acc_hi <= {c, s[15:1]} and q <= {s[0], q[15:1]}, then increment count.
    - After the iteration with count==15, go to DONE.
  - DONE: out_valid=1 and product={acc_hi,q}, held stable until out_ready. On out_valid && out_ready, go to IDLE.
- In BUSY and DONE, in_valid is ignored and in_ready=0. No operand is accepted in the DONE handoff cycle.
- Carry-out of the adder is never lost; it becomes acc_hi[15].
- Overflow is impossible because the result width is 32.
- Reset values: state=IDLE, all data registers and count 0, out_valid=0, product=0, in_ready=0 while rst is high.
- Reset mid-operation aborts with no output: the next cycle is IDLE with in_ready=1.

## Timing
- Accept edge T. BUSY iterations occupy edges T+1..T+16. out_valid is high from the cycle after edge T+16.
- Fixed latency is 16 cycles from acceptance to out_valid (default build).
- Minimum initiation interval is 18 cycles: accept, 16 BUSY cycles, DONE with out_ready=1.
- out_ready held low stalls DONE indefinitely; product must not change while stalled.
- in_valid and out_ready have no combinational paths to outputs. in_ready depends only on state and rst.

## Configuration
- `SEQ_MULT_EARLY_TERM_EN` defined:
  - At the start of each BUSY cycle with count<16, test the unprocessed multiplier bits q & ((1<<(16-count))-1).
  - If they are zero, load {acc_hi,q} <= {acc_hi,q} >> (16-count) and go directly to DONE.
  - Latency becomes min(h+2,16) cycles, where h is the index of the highest set bit of b. b=0 gives 1 cycle.
- Undefined: the comparator and shifter are absent and latency is always 16. The product is identical in both builds.

## Structure
- Package `mult_pkg` holds:
  - `MULT_W`=16, `CNT_W`=5
  - state typedef {IDLE, BUSY, DONE}
  - `LAST_ITER`=15
- Exactly one sub-module: an instance of the existing `brent_kung_16` as the iteration adder, with cin tied to 0.
- All control and shift logic lives in this module.

## Test plan
- a=0x1234, b=0x5678, out_ready=1: product=0x06260060 with out_valid 16 cycles after accept (default build).
- a=0xFFFF, b=0xFFFF: product=0xFFFE0001. Carry-out is propagated on every iteration.
- Backpressure:
  - Stimulus: a=0x0003, b=0x0005, out_ready low for 5 cycles, in_valid held high throughout.
  - Response: product=0x0000000F held stable, in_ready=0 until the handoff, then IDLE accepts the next operands.
- Reset mid-operation: assert rst at the 8th BUSY cycle. Next cycle is IDLE, out_valid=0, no product is ever emitted, and the following a=2, b=3 yields 6.
- With `SEQ_MULT_EARLY_TERM_EN`: b=0 gives product 0 after 1 cycle, b=0x0005 gives 4 cycles, b=0x8000 gives 16 cycles; a=0xABCD in all cases.
- Random regression: 10k random a/b with random out_ready against a*b reference in both builds, and zero mismatches.
